vga_timing_gen: RTL and testbench

Parametrised VGA timing generator, successor of the fixed 800x600 `vga_timing`. It produces horizontal/vertical counters, sync and blanking for any resolution set by parameters, with programmable sync polarity. It adds a pixel clock-enable, a synchronous restart for genlock, and line/frame start pulses. It sits at the head of the video pipeline and feeds the draw/overlay stages.

---
 rtl/vga_timing_gen.sv | 105 ++++++++++
 tb/tb_vga_timing_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA counters, sync, blanking and line/frame pulses.
// Define VGA_TIMING_FRAME_CNT_EN to implement the 16-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_timing_gen #(
  parameter int CW       = 11,
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          restart,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  // Decode thresholds are one bit wider so a sync end equal to 2**CW stays representable
  localparam logic [CW:0] H_BL = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SS = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SE = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_BL = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SS = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SE = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HP = (H_POL != 0);
  localparam logic VP = (V_POL != 0);

  if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_size_chk
    $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 2**CW");
  end

  logic [CW-1:0] r_h, r_v, w_hn, w_vn;
  logic [CW:0]   w_hx, w_vx;
  logic          w_hwrap, w_vwrap, w_hstep;
  logic          r_hsync, r_vsync, r_hblnk, r_vblnk, r_ls, r_fs;

  always_comb begin
    w_hwrap = (r_h == H_LAST);
    w_vwrap = (r_v == V_LAST);
    w_hstep = ce & w_hwrap;
    w_hn    = restart ? '0 : ce ? (w_hwrap ? '0 : r_h + 1'b1) : r_h;
    w_vn    = restart ? '0 : w_hstep ? (w_vwrap ? '0 : r_v + 1'b1) : r_v;
    w_hx    = {1'b0, w_hn};
    w_vx    = {1'b0, w_vn};
  end

  // Flags are decoded from the next counts so they line up with the registered counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h     <= '0;
      r_v     <= '0;
      r_hsync <= ~HP;
      r_vsync <= ~VP;
      r_hblnk <= 1'b0;
      r_vblnk <= 1'b0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_h     <= w_hn;
      r_v     <= w_vn;
      r_hsync <= (w_hx >= H_SS && w_hx < H_SE) ? HP : ~HP;
      r_vsync <= (w_vx >= V_SS && w_vx < V_SE) ? VP : ~VP;
      r_hblnk <= (w_hx >= H_BL);
      r_vblnk <= (w_vx >= V_BL);
      r_ls    <= restart | w_hstep;
      r_fs    <= restart | (w_hstep & w_vwrap);
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_frame_cnt <= '0;
    else if (w_hstep & w_vwrap & ~restart) r_frame_cnt <= r_frame_cnt + 1'b1;
  end
  assign frame_cnt = r_frame_cnt;
`else
  assign frame_cnt = '0;
`endif

  assign hcount      = r_h;
  assign vcount      = r_v;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign hblnk       = r_hblnk;
  assign vblnk       = r_vblnk;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench with a default 800x600 instance and a tiny active-low instance for frame-level behaviour.
`timescale 1ns/1ps
module tb_vga_timing_gen;
  logic clk = 1'b0, rst = 1'b1;
  logic d_ce = 1'b0, d_rs = 1'b0, s_ce = 1'b0, s_rs = 1'b0;
  logic [10:0] d_h, d_v;
  logic [4:0]  s_h, s_v;
  logic d_hs, d_vs, d_hb, d_vb, d_ls, d_fs;
  logic s_hs, s_vs, s_hb, s_vb, s_ls, s_fs;
  logic [15:0] d_fc, s_fc;
  int checks = 0, errors = 0;
  int e_h, e_v, ef;
`ifdef VGA_TIMING_FRAME_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  vga_timing_gen u_d (
    .clk(clk), .rst(rst), .ce(d_ce), .restart(d_rs),
    .hcount(d_h), .vcount(d_v), .hsync(d_hs), .vsync(d_vs),
    .hblnk(d_hb), .vblnk(d_vb), .line_start(d_ls), .frame_start(d_fs),
    .frame_cnt(d_fc)
  );

  // H: 6/2/3/2 -> total 13, sync 8..10; V: 4/1/2/2 -> total 9, sync 5..6; both active-low
  vga_timing_gen #(
    .CW(5), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .H_POL(0), .V_POL(0)
  ) u_s (
    .clk(clk), .rst(rst), .ce(s_ce), .restart(s_rs),
    .hcount(s_h), .vcount(s_v), .hsync(s_hs), .vsync(s_vs),
    .hblnk(s_hb), .vblnk(s_vb), .line_start(s_ls), .frame_start(s_fs),
    .frame_cnt(s_fc)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic s_adv;
    e_h++;
    if (e_h == 13) begin
      e_h = 0;
      e_v++;
      if (e_v == 9) begin
        e_v = 0;
        ef++;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if ({d_h, d_v} !== 22'd0) begin errors++; $display("FAIL reset_counts got %0d,%0d want 0,0", d_h, d_v); end
    checks++; if ({d_hs, d_vs, d_hb, d_vb, d_ls, d_fs} !== 6'b000000) begin errors++; $display("FAIL reset_flags_d got %b want 000000", {d_hs, d_vs, d_hb, d_vb, d_ls, d_fs}); end
    checks++; if ({s_hs, s_vs, s_hb, s_vb} !== 4'b1100) begin errors++; $display("FAIL reset_flags_s got %b want 1100", {s_hs, s_vs, s_hb, s_vb}); end
    checks++; if (d_fc !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d want 0", d_fc); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (d_h !== 11'd0 || d_ls !== 1'b0 || d_fs !== 1'b0) begin errors++; $display("FAIL release_no_pulse got h=%0d ls=%b fs=%b want 0,0,0", d_h, d_ls, d_fs); end
  endtask

  task automatic test_default_line;
    int nls;
    d_ce = 1'b1;
    for (int k = 1; k <= 1056; k++) begin
      tick();
      e_h = k % 1056;
      e_v = k / 1056;
      checks++; if (d_h !== 11'(e_h) || d_v !== 11'(e_v)) begin errors++; $display("FAIL d_count k=%0d got %0d,%0d want %0d,%0d", k, d_h, d_v, e_h, e_v); end
      checks++; if (d_hs !== (e_h >= 840 && e_h <= 967)) begin errors++; $display("FAIL d_hsync h=%0d got %b", e_h, d_hs); end
      checks++; if (d_hb !== (e_h >= 800)) begin errors++; $display("FAIL d_hblnk h=%0d got %b", e_h, d_hb); end
      checks++; if (d_ls !== (e_h == 0)) begin errors++; $display("FAIL d_line_start h=%0d got %b", e_h, d_ls); end
      checks++; if ({d_fs, d_vs, d_vb} !== 3'b000) begin errors++; $display("FAIL d_vflags h=%0d got %b want 000", e_h, {d_fs, d_vs, d_vb}); end
    end
    nls = 0;
    for (int k = 0; k < 44 * 1056 + 123; k++) begin
      tick();
      if (d_ls === 1'b1) nls++;
    end
    checks++; if (d_h !== 11'd123 || d_v !== 11'd45) begin errors++; $display("FAIL d_run got %0d,%0d want 123,45", d_h, d_v); end
    checks++; if (nls !== 44) begin errors++; $display("FAIL d_line_pulses got %0d want 44", nls); end
  endtask

  task automatic test_rst_mid;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({d_h, d_v} !== 22'd0) begin errors++; $display("FAIL rst_async got %0d,%0d want 0,0", d_h, d_v); end
    checks++; if ({d_hs, d_vs, d_hb, d_vb, d_ls, d_fs} !== 6'b000000 || d_fc !== 16'd0) begin errors++; $display("FAIL rst_async_flags got %b fc=%0d", {d_hs, d_vs, d_hb, d_vb, d_ls, d_fs}, d_fc); end
    repeat (3) tick();
    checks++; if ({d_h, d_v} !== 22'd0) begin errors++; $display("FAIL rst_held got %0d,%0d want 0,0", d_h, d_v); end
    rst = 1'b0;
    tick();
    checks++; if (d_h !== 11'd1 || d_v !== 11'd0 || d_ls !== 1'b0 || d_fc !== 16'd0) begin errors++; $display("FAIL rst_resume got h=%0d v=%0d ls=%b fc=%0d want 1,0,0,0", d_h, d_v, d_ls, d_fc); end
    d_ce = 1'b0;
  endtask

  task automatic test_small_frames;
    int nfs, last;
    e_h = 0; e_v = 0; ef = 0; nfs = 0; last = 0;
    s_ce = 1'b1;
    for (int k = 1; k <= 351; k++) begin
      tick();
      s_adv();
      if (s_fs === 1'b1) begin nfs++; last = k; end
      checks++; if (s_h !== 5'(e_h) || s_v !== 5'(e_v)) begin errors++; $display("FAIL s_count k=%0d got %0d,%0d want %0d,%0d", k, s_h, s_v, e_h, e_v); end
      checks++; if (s_hs !== !(e_h >= 8 && e_h <= 10) || s_vs !== !(e_v >= 5 && e_v <= 6)) begin errors++; $display("FAIL s_sync h=%0d v=%0d got %b%b", e_h, e_v, s_hs, s_vs); end
      checks++; if (s_hb !== (e_h >= 6) || s_vb !== (e_v >= 4)) begin errors++; $display("FAIL s_blank h=%0d v=%0d got %b%b", e_h, e_v, s_hb, s_vb); end
      checks++; if (s_ls !== (e_h == 0) || s_fs !== (e_h == 0 && e_v == 0)) begin errors++; $display("FAIL s_pulses h=%0d v=%0d got %b%b", e_h, e_v, s_ls, s_fs); end
      checks++; if (s_fc !== 16'(FC_EN ? ef : 0)) begin errors++; $display("FAIL s_frame_cnt k=%0d got %0d want %0d", k, s_fc, FC_EN ? ef : 0); end
    end
    checks++; if (nfs !== 3 || last !== 351) begin errors++; $display("FAIL s_frame_period got n=%0d last=%0d want 3,351", nfs, last); end
  endtask

  task automatic test_ce_toggle;
    int nfs, last;
    nfs = 0; last = 0;
    for (int k = 1; k <= 234; k++) begin
      s_ce = (k % 2 == 1);
      tick();
      if (s_ce) s_adv();
      if (s_fs === 1'b1) begin nfs++; last = k; end
      checks++; if (s_h !== 5'(e_h) || s_v !== 5'(e_v)) begin errors++; $display("FAIL ce_count k=%0d got %0d,%0d want %0d,%0d", k, s_h, s_v, e_h, e_v); end
      checks++; if (s_ls !== (s_ce && e_h == 0)) begin errors++; $display("FAIL ce_line_start k=%0d got %b", k, s_ls); end
      checks++; if (s_hs !== !(e_h >= 8 && e_h <= 10)) begin errors++; $display("FAIL ce_hsync k=%0d got %b", k, s_hs); end
    end
    checks++; if (nfs !== 1 || last !== 233) begin errors++; $display("FAIL ce_frame_period got n=%0d last=%0d want 1,233", nfs, last); end
  endtask

  task automatic test_restart;
    s_ce = 1'b1;
    repeat (44) begin tick(); s_adv(); end
    checks++; if (s_h !== 5'd5 || s_v !== 5'd3) begin errors++; $display("FAIL rs_pre got %0d,%0d want 5,3", s_h, s_v); end
    s_rs = 1'b1;
    tick();
    s_rs = 1'b0;
    checks++; if (s_h !== 5'd0 || s_v !== 5'd0 || s_ls !== 1'b1 || s_fs !== 1'b1) begin errors++; $display("FAIL rs_mid got %0d,%0d ls=%b fs=%b want 0,0,1,1", s_h, s_v, s_ls, s_fs); end
    checks++; if (s_fc !== 16'(FC_EN ? ef : 0)) begin errors++; $display("FAIL rs_mid_fc got %0d want %0d", s_fc, FC_EN ? ef : 0); end
    tick();
    checks++; if (s_h !== 5'd1 || s_ls !== 1'b0 || s_fs !== 1'b0) begin errors++; $display("FAIL rs_after got h=%0d ls=%b fs=%b want 1,0,0", s_h, s_ls, s_fs); end
    e_h = 1; e_v = 0;
    repeat (115) begin tick(); s_adv(); end
    checks++; if (s_h !== 5'd12 || s_v !== 5'd8) begin errors++; $display("FAIL rs_pre_wrap got %0d,%0d want 12,8", s_h, s_v); end
    s_rs = 1'b1;
    tick();
    s_rs = 1'b0;
    checks++; if (s_h !== 5'd0 || s_v !== 5'd0 || s_fs !== 1'b1) begin errors++; $display("FAIL rs_wrap got %0d,%0d fs=%b want 0,0,1", s_h, s_v, s_fs); end
    checks++; if (s_fc !== 16'(FC_EN ? ef : 0)) begin errors++; $display("FAIL rs_wrap_fc got %0d want %0d", s_fc, FC_EN ? ef : 0); end
    tick(); tick();
    checks++; if (s_h !== 5'd2) begin errors++; $display("FAIL rs_run got %0d want 2", s_h); end
    s_ce = 1'b0;
    s_rs = 1'b1;
    tick();
    s_rs = 1'b0;
    checks++; if (s_h !== 5'd0 || s_ls !== 1'b1 || s_fs !== 1'b1) begin errors++; $display("FAIL rs_no_ce got h=%0d ls=%b fs=%b want 0,1,1", s_h, s_ls, s_fs); end
    tick();
    checks++; if (s_h !== 5'd0 || s_ls !== 1'b0 || s_fs !== 1'b0) begin errors++; $display("FAIL rs_hold got h=%0d ls=%b fs=%b want 0,0,0", s_h, s_ls, s_fs); end
  endtask

  task automatic test_frame_wrap;
    logic [15:0] pre;
    pre = 16'd0;
`ifdef VGA_TIMING_FRAME_CNT_EN
    force u_s.r_frame_cnt = 16'hFFFF;
    #1;
    release u_s.r_frame_cnt;
    pre = 16'hFFFF;
`endif
    #1;
    checks++; if (s_fc !== pre) begin errors++; $display("FAIL fc_preset got %0h want %0h", s_fc, pre); end
    s_ce = 1'b1;
    repeat (117) tick();
    checks++; if (s_h !== 5'd0 || s_v !== 5'd0 || s_fs !== 1'b1) begin errors++; $display("FAIL fc_frame got %0d,%0d fs=%b want 0,0,1", s_h, s_v, s_fs); end
    checks++; if (s_fc !== 16'd0) begin errors++; $display("FAIL fc_wrap got %0h want 0", s_fc); end
    s_ce = 1'b0;
  endtask

  initial begin
    #12;
    test_reset();
    test_default_line();
    test_rst_mid();
    test_small_frames();
    test_ce_toggle();
    test_restart();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
